gpr_xfer_ctrl: RTL and testbench



---
 rtl/gpr_xfer_ctrl.sv | 111 +++++++++++
 tb/tb_gpr_xfer_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_xfer_ctrl.sv
// Register-transfer sequencer for the GPR file: turns one src/dst/wr command
// into one-hot read-select (RA) and store (SR) strobes over READ/EXEC/DONE.
module gpr_xfer_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int CNT_W    = 8
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                start,
  input  logic [SEL_W-1:0]    src,
  input  logic [SEL_W-1:0]    dst,
  input  logic                wr,
  input  logic                stall,
  output logic [NUM_REGS-1:0] RA,
  output logic [NUM_REGS-1:0] SR,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    xfer_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [SEL_W-1:0]   src_q, dst_q;
  logic               wr_q;
  logic [NUM_REGS-1:0] ra_sel, sr_sel;

  // Indices outside the register file select nothing.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign ra_sel = onehot(src_q);
  assign sr_sel = onehot(dst_q);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= S_IDLE;
    else      state <= state_nx;
  end

  // NOTE: the captured command is reset too, so a transfer aborted by CLR
  // leaves no stale select behind for the next command.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      src_q <= '0;
      dst_q <= '0;
      wr_q  <= 1'b0;
    end else if (state == S_IDLE && start) begin
      src_q <= src;
      dst_q <= dst;
      wr_q  <= wr;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                 xfer_cnt <= '0;
    else if (state == S_DONE) xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  state_nx = S_EXEC;
      S_EXEC:  if (!stall) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decode from flops only; stall gating SR in EXEC is the one
  // combinational path from a live input, so a held transfer never stores.
  always_comb begin
    RA   = '0;
    SR   = '0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_READ: begin
        RA   = ra_sel;
        busy = 1'b1;
      end
      S_EXEC: begin
        RA   = ra_sel;
        SR   = (wr_q && !stall) ? sr_sel : '0;
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpr_xfer_ctrl.sv
// Scoreboard bench for gpr_xfer_ctrl: a transfer-level timing model pushes
// expected records at issue; a negedge monitor pops and compares on done.
module tb_gpr_xfer_ctrl;
  localparam int NR = 8;
  localparam int SW = 3;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          CLR = 1'b0;
  logic          start = 1'b0;
  logic          wr = 1'b0;
  logic          stall = 1'b0;
  logic [SW-1:0] src = '0;
  logic [SW-1:0] dst = '0;
  logic [NR-1:0] RA, SR;
  logic          busy, done;
  logic [CW-1:0] xfer_cnt;

  gpr_xfer_ctrl #(.NUM_REGS(NR), .SEL_W(SW), .CNT_W(CW)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .src(src), .dst(dst), .wr(wr),
    .stall(stall), .RA(RA), .SR(SR), .busy(busy), .done(done),
    .xfer_cnt(xfer_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            read_cyc;
    int            sr_cyc;
    int            done_cyc;
    logic [NR-1:0] ra;
    logic [NR-1:0] sr;
    logic [CW-1:0] cnt;
  } xfer_t;

  xfer_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int next_free = 0;
  int stall_lo = -1;
  int stall_hi = -2;
  int sr_cycle = -1;
  int model_cnt = 0;
  int done_seen = 0;
  int issued = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NR-1:0] sel(input logic [SW-1:0] idx);
    return (int'(idx) < NR) ? (NR'(1) << idx) : '0;
  endfunction

  // One clock of stimulus. The model: a start seen at or after next_free is
  // accepted; READ follows, then EXEC for ns stalled cycles plus one, then DONE.
  task automatic drive_cycle(input logic st, input logic [SW-1:0] s, input logic [SW-1:0] d,
                             input logic w, input int ns);
    xfer_t x;
    @(posedge CLK);
    #1;
    if (cyc >= stall_lo && cyc <= stall_hi) stall = 1'b1;
    else if (cyc == sr_cycle)               stall = 1'b0;
    else                                    stall = 1'($urandom_range(0, 1));
    start = st;
    src   = s;
    dst   = d;
    wr    = w;
    if (st && cyc >= next_free) begin
      model_cnt  = (model_cnt + 1) % (1 << CW);
      x.read_cyc = cyc + 1;
      x.sr_cyc   = cyc + 2 + ns;
      x.done_cyc = cyc + 3 + ns;
      x.ra       = sel(s);
      x.sr       = w ? sel(d) : '0;
      x.cnt      = CW'(model_cnt);
      sb.push_back(x);
      stall_lo  = cyc + 2;
      stall_hi  = cyc + 1 + ns;
      sr_cycle  = cyc + 2 + ns;
      next_free = cyc + 4 + ns;
      issued++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, SW'($urandom_range(0, 7)), SW'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), 0);
  endtask

  // Monitor: tracks each busy window and compares it against the scoreboard.
  logic          in_xfer = 1'b0;
  logic          ra_ok = 1'b0;
  logic          cnt_pend = 1'b0;
  logic [CW-1:0] cnt_exp = '0;
  logic [NR-1:0] ra_first = '0;
  logic [NR-1:0] sr_v = '0;
  int            sr_n = 0;
  int            sr_at = -1;
  int            t0 = 0;
  xfer_t         mx;

  always @(negedge CLK) begin
    if (!CLR) begin
      in_xfer  = 1'b0;
      cnt_pend = 1'b0;
    end else begin
      check("ra_popcount", 32'($countones(RA) <= 1), 1);
      check("sr_popcount", 32'($countones(SR) <= 1), 1);
      check("sr_implies_ra", 32'((SR == '0) || (RA != '0)), 1);
      if (cnt_pend) begin
        check("xfer_cnt", 32'(xfer_cnt), 32'(cnt_exp));
        cnt_pend = 1'b0;
      end
      if (busy) begin
        if (!in_xfer) begin
          in_xfer  = 1'b1;
          t0       = cyc;
          ra_first = RA;
          ra_ok    = 1'b1;
          sr_n     = 0;
          sr_v     = '0;
          sr_at    = -1;
        end
        if (!done) begin
          if (RA != ra_first) ra_ok = 1'b0;
          if (SR != '0) begin
            sr_n++;
            sr_v  = SR;
            sr_at = cyc;
          end
        end else begin
          done_seen++;
          in_xfer = 1'b0;
          check("done_ra_sr_zero", 32'({RA, SR}), 0);
          check("done_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            mx = sb.pop_front();
            check("read_cycle", t0, mx.read_cyc);
            check("done_cycle", cyc, mx.done_cyc);
            check("ra_value", 32'(ra_first), 32'(mx.ra));
            check("ra_held", 32'(ra_ok), 1);
            check("sr_strobes", sr_n, (mx.sr != '0) ? 1 : 0);
            check("sr_value", 32'(sr_v), 32'(mx.sr));
            if (mx.sr != '0) check("sr_cycle", sr_at, mx.sr_cyc);
            cnt_exp  = mx.cnt;
            cnt_pend = 1'b1;
          end
        end
      end else begin
        check("idle_outputs", 32'({RA, SR, done}), 0);
      end
    end
  end

  initial begin
    int d0;
    int guard;
    CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ra", 32'(RA), 0);
    check("rst_sr", 32'(SR), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cnt", 32'(xfer_cnt), 0);
    CLR = 1'b1;

    // Single move, read-only, stalled transfer.
    drive_cycle(1'b1, 3'd3, 3'd5, 1'b1, 0);
    idle(4);
    drive_cycle(1'b1, 3'd7, 3'd1, 1'b0, 0);
    idle(4);
    drive_cycle(1'b1, 3'd1, 3'd2, 1'b1, 3);
    idle(7);

    // start held for 10 cycles: starts while busy are dropped.
    d0 = done_seen;
    repeat (10) drive_cycle(1'b1, 3'd4, 3'd6, 1'b1, 0);
    check("b2b_done_count", done_seen - d0, 2);
    idle(5);

    // Asynchronous reset while SR is being driven in EXEC.
    drive_cycle(1'b1, 3'd2, 3'd6, 1'b1, 0);
    idle(2);
    #1;
    check("pre_rst_sr", 32'(SR), 32'(sel(3'd6)));
    check("pre_rst_ra", 32'(RA), 32'(sel(3'd2)));
    CLR = 1'b0;
    #1;
    check("async_rst_ra", 32'(RA), 0);
    check("async_rst_sr", 32'(SR), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_cnt", 32'(xfer_cnt), 0);
    sb.delete();
    model_cnt = 0;
    next_free = 0;
    stall_lo  = -1;
    stall_hi  = -2;
    sr_cycle  = -1;
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    drive_cycle(1'b1, 3'd0, 3'd7, 1'b1, 1);
    idle(6);

    // Random traffic, enough to wrap the transfer counter.
    d0 = issued;
    while (issued - d0 < 300 && cyc < 20000)
      drive_cycle(1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)),
                  SW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3));

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      idle(1);
      guard++;
    end
    check("drain_empty", sb.size(), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
